// File: rtl/cx_pkg.sv
// Shared types for the compare-and-exchange controller.
// The CLEAR state exists only when CX_CLEAR_EN is defined.
package cx_pkg;

  typedef logic [31:0] regval_t;

`ifdef CX_CLEAR_EN
  typedef enum logic [2:0] {IDLE, READ, COMMIT, DONE, CLEAR} cx_state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, COMMIT, DONE} cx_state_t;
`endif

  function automatic logic cx_match(input regval_t a, input regval_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/cx_controller_rr_arbiter.sv
// Combinational round-robin arbiter: searches from core last_grant+1 upward,
// wrapping modulo N_CORES, and reports the first requester found.
module cx_rr_arbiter #(
  parameter int N_CORES = 4
) (
  input  logic [N_CORES-1:0]         req,
  input  logic [$clog2(N_CORES)-1:0] last_grant,
  output logic                       valid,
  output logic [$clog2(N_CORES)-1:0] grant
);

  localparam int CORE_W = $clog2(N_CORES);

  int cand;

  always_comb begin
    valid = 1'b0;
    grant = '0;
    cand  = 0;
    for (int i = 1; i <= N_CORES; i++) begin
      cand = (int'(last_grant) + i) % N_CORES;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = CORE_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cx_controller.sv
// Multi-core compare-and-exchange controller over a single-port synchronous RAM.
// Optional build macro CX_CLEAR_EN: zero the whole memory after every reset.
module cx_controller
  import cx_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int INDEX_W = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [N_CORES-1:0]           req,
  input  logic [N_CORES*INDEX_W-1:0]   req_index,
  input  logic [N_CORES*32-1:0]        req_comparand,
  input  logic [N_CORES*32-1:0]        req_replacement,
  output logic [N_CORES-1:0]           ack,
  output regval_t                      original,
  output logic                         success,
  output logic                         busy
);

  localparam int CORE_W = $clog2(N_CORES);
  localparam int DEPTH  = 2**INDEX_W;

  cx_state_t          state, state_next;
  logic [CORE_W-1:0]  last_grant, winner, arb_grant;
  logic               arb_valid;
  logic [INDEX_W-1:0] idx_q;
  regval_t            cmp_q, rep_q, rdata;
  regval_t            mem [DEPTH];
  logic               mem_we;
  logic [INDEX_W-1:0] mem_addr;
  regval_t            mem_wdata;
`ifdef CX_CLEAR_EN
  logic [INDEX_W-1:0] clr_addr;
`endif

  function automatic logic [N_CORES-1:0] onehot(input logic [CORE_W-1:0] id);
    logic [N_CORES-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  cx_rr_arbiter #(.N_CORES(N_CORES)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_valid) state_next = READ;
      READ:    state_next = COMMIT;
      COMMIT:  state_next = DONE;
      DONE:    state_next = IDLE;
`ifdef CX_CLEAR_EN
      CLEAR:   if (clr_addr == {INDEX_W{1'b1}}) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // control: state, grant history and the completion outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
`ifdef CX_CLEAR_EN
      state    <= CLEAR;
      clr_addr <= '0;
`else
      state    <= IDLE;
`endif
      ack        <= '0;
      success    <= 1'b0;
      original   <= '0;
      last_grant <= CORE_W'(N_CORES - 1);
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (arb_valid) begin
          last_grant <= arb_grant;
          winner     <= arb_grant;
        end
        COMMIT: begin
          ack      <= onehot(winner);
          success  <= cx_match(rdata, cmp_q);
          original <= rdata;
        end
        DONE: ack <= '0;
`ifdef CX_CLEAR_EN
        CLEAR: clr_addr <= clr_addr + 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // operands are captured once at grant; later req changes cannot disturb them
  always_ff @(posedge clock) begin
    if (state == IDLE && arb_valid) begin
      idx_q <= req_index[int'(arb_grant)*INDEX_W +: INDEX_W];
      cmp_q <= req_comparand[int'(arb_grant)*32 +: 32];
      rep_q <= req_replacement[int'(arb_grant)*32 +: 32];
    end
  end

  always_comb begin
    mem_addr  = idx_q;
    mem_wdata = rep_q;
    mem_we    = reset_n && (state == COMMIT) && cx_match(rdata, cmp_q);
`ifdef CX_CLEAR_EN
    if (state == CLEAR) begin
      mem_addr  = clr_addr;
      mem_wdata = '0;
      mem_we    = reset_n;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (state == READ) rdata <= mem[mem_addr];
  end

endmodule

// File: tb/tb_cx_controller.sv
// Directed bench for cx_controller (N_CORES=4, INDEX_W=4); works with or
// without CX_CLEAR_EN defined.
module tb_cx_controller;

  localparam int N  = 4;
  localparam int IW = 4;
`ifdef CX_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req;
  logic [N*IW-1:0]   req_index;
  logic [N*32-1:0]   req_comparand;
  logic [N*32-1:0]   req_replacement;
  logic [N-1:0]      ack;
  logic [31:0]       original;
  logic              success;
  logic              busy;

  int checks = 0;
  int errors = 0;

  cx_controller #(.N_CORES(N), .INDEX_W(IW)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req             (req),
    .req_index       (req_index),
    .req_comparand   (req_comparand),
    .req_replacement (req_replacement),
    .ack             (ack),
    .original        (original),
    .success         (success),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          core;
    logic [3:0]  idx;
    logic [31:0] cmp;
    logic [31:0] rep;
    logic [31:0] exp_orig;
    logic        exp_succ;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_op(input int core, input logic [3:0] idx, input logic [31:0] cmp,
                        input logic [31:0] rep);
    req_index[core*IW +: IW]     = idx;
    req_comparand[core*32 +: 32] = cmp;
    req_replacement[core*32 +: 32] = rep;
  endtask

  // Issue one CX and wait (bounded) for its ack; returns in IDLE.
  task automatic do_cx(input int core, input logic [3:0] idx, input logic [31:0] cmp,
                       input logic [31:0] rep, output logic [31:0] orig,
                       output logic succ, output logic [3:0] ackv);
    int n;
    set_op(core, idx, cmp, rep);
    req[core] = 1'b1;
    ackv = '0; orig = '0; succ = 1'b0; n = 0;
    while (ackv == 0 && n < 12) begin
      tick();
      n++;
      if (ack != 0) begin
        ackv = ack; orig = original; succ = success;
      end
    end
    req[core] = 1'b0;
    tick();
  endtask

  // Puts a known zero into memory[idx] regardless of power-up contents.
  task automatic init_word(input logic [3:0] idx);
    logic [31:0] o, o2;
    logic s, s2;
    logic [3:0] a, a2;
    do_cx(0, idx, 32'h0, 32'h0, o, s, a);
    do_cx(0, idx, o, 32'h0, o2, s2, a2);
    check("init_success", {31'b0, s2}, 32'd1);
  endtask

  task automatic do_reset(output int cnt);
    req = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    logic [31:0] o, o1, o2;
    logic s, s1, s2;
    logic [3:0] a, a1, a2;
    int cnt, t, last_t, seen;
    bit width_chk;
    bit any_ack;
    int rr_exp [4];

    vecs[0] = '{0, 4'd3, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 1'b1};
    vecs[1] = '{1, 4'd3, 32'h0000_0000, 32'h0000_0077, 32'h0000_0055, 1'b0};
    vecs[2] = '{2, 4'd3, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0000_0055, 1'b1};
    vecs[3] = '{3, 4'd3, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{3, 4'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{1, 4'd3, 32'h0000_0001, 32'h0000_0000, 32'h8000_0001, 1'b0};
    vecs[6] = '{0, 4'd3, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 1'b1};

    req = '0; req_index = '0; req_comparand = '0; req_replacement = '0;
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_ack", {28'b0, ack}, 32'h0);
    check("rst_success", {31'b0, success}, 32'h0);
    check("rst_original", original, 32'h0);
    check("rst_busy", {31'b0, busy}, {31'b0, CLEAR_EN});
    reset_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
    check("clear_busy_cycles", cnt, CLEAR_EN ? 32'd16 : 32'd0);

    init_word(4'd3);
    for (int i = 0; i < 7; i++) begin
      do_cx(vecs[i].core, vecs[i].idx, vecs[i].cmp, vecs[i].rep, o, s, a);
      check($sformatf("vec%0d_ack", i), {28'b0, a}, 32'(1 << vecs[i].core));
      check($sformatf("vec%0d_original", i), o, vecs[i].exp_orig);
      check($sformatf("vec%0d_success", i), {31'b0, s}, {31'b0, vecs[i].exp_succ});
    end

    // reset landing on the COMMIT edge of a matching request
    init_word(4'd7);
    do_cx(1, 4'd7, 32'h0, 32'h0000_1234, o, s, a);
    check("abort_setup_success", {31'b0, s}, 32'd1);
    set_op(0, 4'd7, 32'h0000_1234, 32'h0000_BEEF);
    req[0] = 1'b1;
    tick();
    tick();
    check("abort_busy_commit", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    req = '0;
    any_ack = 1'b0;
    tick();
    if (ack != 0) any_ack = 1'b1;
    tick();
    if (ack != 0) any_ack = 1'b1;
    reset_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
      if (ack != 0) any_ack = 1'b1;
    end
    check("abort_no_ack", {31'b0, any_ack}, 32'd0);
    do_cx(0, 4'd7, 32'h0, 32'h0, o, s, a);
    check("abort_mem", o, CLEAR_EN ? 32'h0 : 32'h0000_1234);

    // all four cores at once after reset: served 0,1,2,3 four cycles apart
    do_reset(cnt);
    for (int k = 0; k < N; k++) set_op(k, 4'(8 + k), 32'h0, 32'(k));
    req = '1;
    t = 0; last_t = 0; seen = 0; width_chk = 1'b0;
    while (seen < 4 && t < 60) begin
      tick();
      t++;
      if (width_chk) begin
        check("rr_ack_width", {28'b0, ack}, 32'h0);
        width_chk = 1'b0;
      end
      if (ack != 0) begin
        check($sformatf("rr_order%0d", seen), {28'b0, ack}, 32'(1 << seen));
        if (seen > 0) check($sformatf("rr_spacing%0d", seen), t - last_t, 32'd4);
        last_t = t;
        req = req & ~ack;
        seen++;
        width_chk = 1'b1;
      end
    end
    check("rr_all_served", seen, 32'd4);
    req = '0;
    tick();
    check("rr_trailing_width", {28'b0, ack}, 32'h0);

    // core2 held continuously, core0 joins: grants alternate
    rr_exp = '{2, 0, 2, 0};
    set_op(2, 4'd12, 32'h1, 32'h2);
    set_op(0, 4'd13, 32'h1, 32'h2);
    req[2] = 1'b1;
    t = 0; seen = 0;
    while (seen < 4 && t < 60) begin
      tick();
      t++;
      if (ack != 0) begin
        check($sformatf("alt_grant%0d", seen), {28'b0, ack}, 32'(1 << rr_exp[seen]));
        req[0] = 1'b1;
        seen++;
        if (seen == 4) req = '0;
      end
    end
    check("alt_all_served", seen, 32'd4);
    tick();

    // same-index race: second sees the first's replacement
    init_word(4'd5);
    set_op(1, 4'd5, 32'h0, 32'h1);
    set_op(2, 4'd5, 32'h0, 32'h2);
    req[1] = 1'b1;
    req[2] = 1'b1;
    a1 = '0; a2 = '0; o1 = '0; o2 = '0; s1 = 1'b0; s2 = 1'b0;
    t = 0; seen = 0;
    while (seen < 2 && t < 30) begin
      tick();
      t++;
      if (ack != 0) begin
        if (seen == 0) begin a1 = ack; o1 = original; s1 = success; end
        else begin a2 = ack; o2 = original; s2 = success; end
        req = req & ~ack;
        seen++;
      end
    end
    req = '0;
    check("race_first_ack", {28'b0, a1}, 32'h2);
    check("race_first_success", {31'b0, s1}, 32'd1);
    check("race_first_original", o1, 32'h0);
    check("race_second_ack", {28'b0, a2}, 32'h4);
    check("race_second_success", {31'b0, s2}, 32'd0);
    check("race_second_original", o2, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
